pattern_sequencer: RTL and testbench
====================================

# pattern_sequencer

Fetches note events from an external synchronous pattern ROM on request from `channel_controller` and presents one decoded event per request. It returns pitch index, duration and a rest flag. It sits directly upstream of `channel_controller`: its `i_enable` is driven by `o_pattern_enable`, and its `o_valid` drives `i_pattern_valid`. It walks the pattern with a program counter and resolves loop and end control words internally, so the controller only ever sees note or rest events.

## Interface
- `ADDR_WIDTH`, default 8: ROM address width; program counter width.
- `START_ADDR`, default 0: program counter value after reset.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_enable`  in  1  single-cycle request for the next event; ignored unless the block is in IDLE or DONE.
- `o_rom_addr`  out  ADDR_WIDTH  ROM address, registered, equal to the program counter.
- `o_rom_rd`  out  1  ROM read strobe; the ROM returns data on `i_rom_data` in the following cycle.
- `i_rom_data`  in  16  ROM word.
- `o_valid`  out  1  single-cycle pulse; event outputs are valid.
- `o_pitch`  out  6  pitch-table index.
- `o_duration`  out  8  duration in note strobes.
- `o_rest`  out  1  event is a rest.
- `o_done`  out  1  level; pattern has ended.

## Operation
- ROM word format:
  - [15:14] is the opcode.
  - 00 NOTE: pitch = [13:8], duration = [7:0].
  - 01 REST: duration = [7:0]; pitch output is 0.
  - 10 LOOP: repeat count = [13:8], where 0 means forever; target address = [ADDR_WIDTH-1:0].
  - 11 END.
- State machine states: IDLE, FETCH, DECODE, DONE.
- IDLE: when `i_enable` is high, go to FETCH.
- FETCH: assert `o_rom_rd` with `o_rom_addr` = pc; go to DECODE.
- DECODE (`i_rom_data` valid):
  - NOTE or REST: register the outputs, pulse `o_valid`, pc <= pc+1, go to IDLE.
  - LOOP:
    - count == 0: pc <= target.
    - loop_cnt < count: loop_cnt++, pc <= target.
    - otherwise: loop_cnt <= 0, pc <= pc+1.
    - In all three cases go to FETCH.
  - END: set `o_done`, pulse `o_valid` with rest=1, duration=0, pitch=0; go to DONE. pc holds.
- Runaway guard:
  - A counter of consecutive control words is incremented on LOOP and cleared on NOTE/REST.
  - When a LOOP is decoded with the counter already at 3 (the 4th consecutive LOOP), treat it as END.
- DONE: every `i_enable` produces an `o_valid` pulse 1 cycle later, with rest=1, duration=0, pitch=0, and `o_done` held high. The only exit is reset.
- There is one loop counter and no nesting. A second LOOP word reuses the counter as-is.
- pc wraps from 2^ADDR_WIDTH-1 to 0. The wrap is not an error.
- `o_pitch`, `o_duration` and `o_rest` hold their values between `o_valid` pulses.

## Timing
- Reset values:
  - state = IDLE, pc = START_ADDR, loop_cnt = 0, control-word counter = 0.
  - `o_rom_rd` = 0, `o_rom_addr` = START_ADDR.
  - `o_valid` = 0, `o_pitch` = 0, `o_duration` = 0, `o_rest` = 0, `o_done` = 0.
- NOTE/REST latency: `i_enable` in cycle 0 gives `o_rom_rd` in cycle 1, data in cycle 2, and `o_valid` in cycle 3.
- Each LOOP word resolved adds 2 cycles.
- DONE latency: 1 cycle.
- `i_enable` in FETCH or DECODE is dropped; no request is queued.
- Reset asserted mid-fetch: all state returns to reset values on the next edge; no `o_valid` is emitted.
- `o_valid` is never high for two consecutive cycles.

## Test plan
- ROM[0] = 0x0510 (NOTE, pitch 5, duration 16). Pulse `i_enable` in cycle 0 -> `o_rom_rd` with addr 0 in cycle 1; `o_valid` in cycle 3 with pitch 5, duration 16, rest 0; pc = 1.
- ROM[1] = 0x4008 (REST, duration 8), requested next -> `o_valid` with rest 1, pitch 0, duration 8.
- ROM[0..2] = NOTE A, NOTE B, LOOP count 2 to target 0; ROM[3] = NOTE C. Issue 7 requests -> events A B A B A B C. Event C takes 5 cycles; loop_cnt returns to 0.
- ROM[0] = END -> `o_valid` in cycle 3 with rest=1, duration=0, and `o_done` high. A later `i_enable` -> `o_valid` 1 cycle after it, with `o_done` still high.
- ROM[0] = LOOP count 0 to target 0 -> after the 4th LOOP decode, an END-style `o_valid` with `o_done`=1; exactly 4 `o_rom_rd` pulses.
- Assert `i_rst` in the DECODE cycle of a NOTE -> no `o_valid`; all outputs return to reset values. An `i_enable` with START_ADDR=4 then fetches address 4.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Walks a pattern ROM and hands one decoded note/rest event to the channel controller per request.
// LOOP and END control words are resolved here, so only note, rest and end events leave this block.
module pattern_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int START_ADDR = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  output logic                  o_rom_rd,
  input  logic [15:0]           i_rom_data,
  output logic                  o_valid,
  output logic [5:0]            o_pitch,
  output logic [7:0]            o_duration,
  output logic                  o_rest,
  output logic                  o_done
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);
  localparam logic [1:0] OP_NOTE = 2'b00;
  localparam logic [1:0] OP_REST = 2'b01;
  localparam logic [1:0] OP_LOOP = 2'b10;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [5:0]            loop_cnt;
  logic [1:0]            ctrl_cnt;

  logic [1:0]            opcode;
  logic [5:0]            field_hi;
  logic [ADDR_WIDTH-1:0] target;

  assign opcode     = i_rom_data[15:14];
  assign field_hi   = i_rom_data[13:8];
  assign target     = i_rom_data[ADDR_WIDTH-1:0];
  assign o_rom_addr = pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      pc         <= START;
      loop_cnt   <= '0;
      ctrl_cnt   <= '0;
      o_rom_rd   <= 1'b0;
      o_valid    <= 1'b0;
      o_pitch    <= '0;
      o_duration <= '0;
      o_rest     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_valid  <= 1'b0;
      o_rom_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable) begin
            o_rom_rd <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (opcode == OP_NOTE || opcode == OP_REST) begin
            o_pitch    <= (opcode == OP_NOTE) ? field_hi : 6'd0;
            o_duration <= i_rom_data[7:0];
            o_rest     <= (opcode == OP_REST);
            o_valid    <= 1'b1;
            pc         <= pc + ADDR_WIDTH'(1);
            ctrl_cnt   <= '0;
            state      <= IDLE;
          end else if (opcode == OP_LOOP && ctrl_cnt != 2'd3) begin
            ctrl_cnt <= ctrl_cnt + 2'd1;
            o_rom_rd <= 1'b1;
            state    <= FETCH;
            if (field_hi == 6'd0) begin
              pc <= target;
            end else if (loop_cnt < field_hi) begin
              loop_cnt <= loop_cnt + 6'd1;
              pc       <= target;
            end else begin
              loop_cnt <= '0;
              pc       <= pc + ADDR_WIDTH'(1);
            end
          end else begin
            // END word, or a fourth consecutive LOOP treated as END; pc holds.
            o_pitch    <= '0;
            o_duration <= '0;
            o_rest     <= 1'b1;
            o_valid    <= 1'b1;
            o_done     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          // Answer each request with an end event; o_valid never stays high two cycles.
          if (i_enable && !o_valid) begin
            o_pitch    <= '0;
            o_duration <= '0;
            o_rest     <= 1'b1;
            o_valid    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: ROM model, request driver, event scoreboard and a second
// instance (START_ADDR=4) for the reset-during-decode case.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, rom_rd, valid, rest, done;
  logic [7:0]  rom_addr, dur;
  logic [15:0] rom_data;
  logic [5:0]  pitch;

  logic        rst2, en2, rom_rd2, valid2, rest2, done2;
  logic [7:0]  rom_addr2, dur2;
  logic [15:0] rom_data2;
  logic [5:0]  pitch2;

  logic [15:0] rom [256];
  logic [15:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          rd_cnt = 0;
  int          valid2_cnt = 0;

  always #5 clk = ~clk;

  pattern_sequencer #(.ADDR_WIDTH(8), .START_ADDR(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .o_rom_addr(rom_addr), .o_rom_rd(rom_rd),
    .i_rom_data(rom_data), .o_valid(valid), .o_pitch(pitch), .o_duration(dur),
    .o_rest(rest), .o_done(done));

  pattern_sequencer #(.ADDR_WIDTH(8), .START_ADDR(4)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_enable(en2), .o_rom_addr(rom_addr2), .o_rom_rd(rom_rd2),
    .i_rom_data(rom_data2), .o_valid(valid2), .o_pitch(pitch2), .o_duration(dur2),
    .o_rest(rest2), .o_done(done2));

  // Synchronous ROM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rom_rd)  rom_data  <= rom[rom_addr];
    if (rom_rd2) rom_data2 <= rom[rom_addr2];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Scoreboard: every o_valid pops one expected {done, rest, pitch, duration}.
  always @(negedge clk) begin
    if (rom_rd) rd_cnt++;
    if (valid2) valid2_cnt++;
    if (valid) begin
      if (exp_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else check("event", {16'd0, done, rest, pitch, dur}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [15:0] ev(input logic d, input logic r, input logic [5:0] p,
                                     input logic [7:0] du);
    return {d, r, p, du};
  endfunction

  // Pulse i_enable for one cycle; check the fetch address and the request-to-valid latency.
  task automatic request(input string tag, input logic [7:0] exp_addr, input int exp_lat,
                         input logic [15:0] exp_ev, input bit check_fetch);
    int n;
    exp_q.push_back(exp_ev);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    n = 1;
    if (check_fetch) check({tag, "_fetch"}, {23'd0, rom_rd, rom_addr}, {23'd0, 1'b1, exp_addr});
    while (!valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
    en2  = 1'b0;
    rst2 = 1'b1;
    reset_dut();
    #1 rst2 = 1'b0;
    check("reset_outputs", {16'd0, rom_rd, valid, rest, done, pitch, dur}, 32'd0);
    check("reset_addr", rom_addr, 0);
    check("reset_addr2", rom_addr2, 4);

    // Single note then a rest; outputs hold afterwards.
    rom[0] = 16'h0510;
    rom[1] = 16'h4008;
    request("note", 8'd0, 3, ev(0, 0, 6'd5, 8'd16), 1);
    @(posedge clk); #1 check("pc_after_note", rom_addr, 1);
    request("rest", 8'd1, 3, ev(0, 1, 6'd0, 8'd8), 1);
    repeat (3) @(posedge clk);
    #1 check("hold", {18'd0, rest, pitch, dur}, {18'd0, 1'b1, 6'd0, 8'd8});

    // Enable during FETCH is dropped: exactly one event, pc advances once.
    reset_dut();
    exp_q.push_back(ev(0, 0, 6'd5, 8'd16));
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("drop_pc", rom_addr, 1);
    check("drop_queue", exp_q.size(), 0);

    // Loop count 2 back to 0: A B A B A B C.
    reset_dut();
    rom[0] = 16'h0A11;
    rom[1] = 16'h0B22;
    rom[2] = 16'h8200;
    rom[3] = 16'h0C33;
    request("loop_a1", 8'd0, 3, ev(0, 0, 6'd10, 8'h11), 1);
    request("loop_b1", 8'd1, 3, ev(0, 0, 6'd11, 8'h22), 1);
    request("loop_a2", 8'd2, 5, ev(0, 0, 6'd10, 8'h11), 1);
    request("loop_b2", 8'd1, 3, ev(0, 0, 6'd11, 8'h22), 1);
    request("loop_a3", 8'd2, 5, ev(0, 0, 6'd10, 8'h11), 1);
    request("loop_b3", 8'd1, 3, ev(0, 0, 6'd11, 8'h22), 1);
    request("loop_c", 8'd2, 5, ev(0, 0, 6'd12, 8'h33), 1);
    check("loop_cnt_cleared", dut.loop_cnt, 0);
    check("pc_after_c", rom_addr, 4);

    // END word, then a DONE-state request answered in one cycle.
    reset_dut();
    rom[0] = 16'hC000;
    request("end", 8'd0, 3, ev(1, 1, 6'd0, 8'd0), 1);
    repeat (2) @(posedge clk);
    request("done_req", 8'd0, 1, ev(1, 1, 6'd0, 8'd0), 0);
    #1 check("done_level", done, 1);

    // Runaway guard: LOOP-forever to itself ends after four LOOP decodes.
    reset_dut();
    rom[0] = 16'h8000;
    rd_cnt = 0;
    request("runaway", 8'd0, 9, ev(1, 1, 6'd0, 8'd0), 1);
    repeat (3) @(posedge clk);
    #1 check("runaway_reads", rd_cnt, 4);

    // Reset asserted in DECODE on the START_ADDR=4 instance.
    rom[4] = 16'h0A20;
    @(posedge clk); #1 en2 = 1'b1;
    @(posedge clk); #1 en2 = 1'b0;
    check("r2_fetch", {23'd0, rom_rd2, rom_addr2}, {23'd0, 1'b1, 8'd4});
    @(posedge clk); #1 rst2 = 1'b1;
    @(posedge clk); #1 rst2 = 1'b0;
    check("r2_reset_outputs", {16'd0, rom_rd2, valid2, rest2, done2, pitch2, dur2}, 32'd0);
    check("r2_reset_addr", rom_addr2, 4);
    en2 = 1'b1;
    @(posedge clk); #1 en2 = 1'b0;
    check("r2_refetch", {23'd0, rom_rd2, rom_addr2}, {23'd0, 1'b1, 8'd4});
    repeat (2) @(posedge clk);
    #1 check("r2_event", {17'd0, valid2, rest2, pitch2, dur2}, {17'd0, 1'b1, 1'b0, 6'd10, 8'h20});
    repeat (2) @(posedge clk);
    #1 check("r2_valid_count", valid2_cnt, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
